// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the data port.
// One transaction at a time; data wins ties; a watchdog aborts unanswered requests.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              if_stall,
   output logic              d_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_t;

   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   state_t     state, state_nxt;
   logic       owner_d;
   logic [7:0] wd_cnt;
   logic       busy;
   logic       grant_d, grant_i;
   logic       ack_hit, timeout_hit;

   assign busy     = (state == I_BUSY) || (state == D_BUSY);
   assign mem_req  = busy;
   assign if_stall = if_req & ~if_ready;
   assign d_stall  = d_req & ~d_ready;

   always_comb begin
      state_nxt   = state;
      grant_d     = 1'b0;
      grant_i     = 1'b0;
      ack_hit     = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (d_req) begin
               grant_d   = 1'b1;
               state_nxt = D_BUSY;
            end else if (if_req) begin
               grant_i   = 1'b1;
               state_nxt = I_BUSY;
            end
         end
         I_BUSY, D_BUSY: begin
            if (mem_ack) begin
               ack_hit   = 1'b1;
               state_nxt = DONE;
            end else if (wd_cnt == WD_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner_d   <= 1'b0;
         wd_cnt    <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         if_ready  <= 1'b0;
         d_ready   <= 1'b0;
         err       <= 1'b0;
      end else begin
         state <= state_nxt;
         // Ready is registered so the DONE cycle carries the pulse with no path from mem_ack.
         if_ready <= (ack_hit | timeout_hit) & ~owner_d;
         d_ready  <= (ack_hit | timeout_hit) & owner_d;
         if (timeout_hit) err <= 1'b1;
         if (grant_d) begin
            owner_d   <= 1'b1;
            wd_cnt    <= '0;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
         end else if (grant_i) begin
            owner_d  <= 1'b0;
            wd_cnt   <= '0;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
         end
         if (busy && !mem_ack) wd_cnt <= wd_cnt + 8'd1;
         if (ack_hit) begin
            if (!owner_d)     if_rdata <= mem_rdata;
            else if (!mem_we) d_rdata  <= mem_rdata;
         end
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter sharing one single-ported unified memory between the pipeline's instruction-fetch (IF) port and data-memory (MEM-stage) port. It accepts one request at a time, drives a req/ack handshake to the memory and returns read data with a one-cycle ready pulse. It also produces stall signals that freeze the PC and pipeline registers, and a watchdog that aborts transactions the memory never acknowledges.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, max cycles in a busy state waiting for mem_ack before abort (1..255)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request (read only)
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, valid when if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request
- d_we  in  1  1=write, 0=read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data, valid when d_ready=1
- d_ready  out  1  one-cycle completion pulse for data
- if_stall  out  1  combinational: if_req & ~if_ready
- d_stall  out  1  combinational: d_req & ~d_ready
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  latched write enable
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, I_BUSY, D_BUSY, DONE.
- IDLE: d_req=1 -> latch d_we/d_addr/d_wdata into mem_* regs, go D_BUSY. Else if_req=1 -> latch mem_we=0, mem_addr=if_addr, go I_BUSY. Else stay. Data has fixed priority (older instruction); simultaneous requests grant data first, fetch in the next IDLE.
- I_BUSY/D_BUSY: mem_req=1, mem_* stable. mem_ack=1 -> capture mem_rdata into if_rdata (I_BUSY) or into d_rdata (D_BUSY, read only; writes leave d_rdata unchanged), go DONE. Owner recorded in an owner bit.
- Watchdog: 8-bit counter cleared on entry to a busy state, increments each busy cycle without ack. When count reaches TIMEOUT-1 and mem_ack=0 -> set err, go DONE; rdata registers unchanged.
- DONE: assert owner's ready for exactly this cycle, mem_req=0; unconditionally go IDLE. Requests ignored in DONE; requester must drop req or present a new one, sampled in the following IDLE cycle.
- mem_ack outside busy states ignored (covers late ack after abort or reset).
- Input req/addr need only be valid in the IDLE cycle they are sampled; arbiter never re-reads them.
- err cleared only by rst.

## Timing
- Reset (rst=1 at an edge): state IDLE; mem_req, mem_we, if_ready, d_ready, err = 0; mem_addr, mem_wdata, if_rdata, d_rdata, counter = 0. Mid-transaction reset drops mem_req the cycle after the edge; transaction is discarded, no ready pulse.
- Min latency: req sampled at edge N (IDLE), mem_req high cycle N+1, ack in N+1 -> ready pulse cycle N+2. Each extra ack-wait cycle adds one.
- Back-to-back: min 3 cycles per transaction (IDLE, BUSY, DONE).
- Timeout: err and ready assert in the same DONE cycle, TIMEOUT busy cycles after grant.
- Stalls combinational from req and registered ready; no path from mem_ack to any output.

## Test plan
- Reset: hold rst 2 cycles during D_BUSY -> mem_req=0, all outputs 0, later mem_ack ignored, no ready pulse.
- Single fetch: if_req, if_addr=0x40, memory acks next cycle with 0x8C010004 -> mem_req 1 cycle, if_ready pulse 2 cycles after request with if_rdata=0x8C010004, if_stall high until then.
- Conflict: if_req and d_req (read 0x100, mem returns 0xDEADBEEF) same cycle -> data served first (d_ready, d_rdata=0xDEADBEEF), then fetch granted in next IDLE; if_stall high throughout.
- Write: d_we=1, d_addr=0x200, d_wdata=0x12345678, ack after 3 wait cycles -> mem_we=1, mem_addr/wdata stable all 4 busy cycles, d_ready pulse, d_rdata unchanged.
- Timeout: TIMEOUT=15, never ack -> after 15 busy cycles DONE with ready pulse and err=1; err stays 1 through later good transactions until rst.
- Late ack: ack arrives in IDLE after timeout -> no state change, no ready pulse.
